uart_ram_loader: RTL and testbench
==================================

// Module: uart_ram_loader
// PURPOSE
//   Upstream loader for the CPU. Receives a program/data image over a UART line (8N1).
//   Packs byte pairs into 16-bit words and writes them to RAM at ascending addresses from 0.
//   Raises a sticky completion flag once the image is loaded; this flag drives the CPU's UART2RAMCompleted input.
//   Owns the RAM write port until completion; the CPU does not run before completion.
// PARAMETERS
//   CLKS_PER_BIT  868  clk cycles per UART bit (100 MHz / 115200); must be >= 4
//   ADDR_W        16   RAM address width
//   WORD_COUNT    256  number of 16-bit words in the image; range 1..2**ADDR_W
// PORTS
//   clk        in   1       system clock, all logic on rising edge
//   rst        in   1       asynchronous, active-high reset
//   rx         in   1       UART serial input, idle high, asynchronous to clk
//   ram_addr   out  ADDR_W  RAM write address (word index)
//   ram_wdata  out  16      RAM write data
//   ram_we     out  1       RAM write enable, one-cycle pulse per word
//   completed  out  1       sticky: image fully written (to CPU UART2RAMCompleted)
//   frame_err  out  1       one-cycle pulse: stop bit sampled low, byte dropped
// BEHAVIOUR
//   Reset: ram_addr=0, ram_wdata=0, ram_we=0, completed=0, frame_err=0; RX FSM=IDLE; byte-pair phase=LOW.
//     Reset asserted mid-frame or mid-image aborts everything; the loader restarts at address 0.
//   rx passes through a 2-flop synchronizer, initialised to 1; all sampling uses the synchronized value.
//   RX FSM states:
//     IDLE:  wait for synchronized rx==0 -> START, bit timer cleared.
//     START: at CLKS_PER_BIT/2 cycles re-sample. If 0 -> DATA (timer cleared, bit index 0).
//            If 1 -> false start, return to IDLE with no output.
//     DATA:  sample every CLKS_PER_BIT cycles, i.e. at the bit centres. 8 bits, LSB first.
//            After bit 7 -> STOP.
//     STOP:  sample after CLKS_PER_BIT cycles.
//            If 1: byte valid.
//            If 0: frame_err pulses 1 cycle, byte discarded, pair phase unchanged.
//            Either way -> IDLE in the same cycle. Back-to-back frames are accepted.
//   Byte packing: the first valid byte of a pair is the low byte (held in a register).
//     The second valid byte is the high byte; the word is {high, low}.
//   Write: the cycle after the second byte's stop sample, ram_we=1 with ram_addr=word index and ram_wdata=word.
//     ram_addr increments by 1 on the cycle after ram_we (wraps modulo 2**ADDR_W, unreachable when WORD_COUNT <= 2**ADDR_W).
//     ram_wdata holds its last value between writes.
//   Completion: after write number WORD_COUNT, completed=1 on the cycle after that ram_we and stays 1 until rst.
//     ram_addr is not incremented past the last word.
//     Once completed: rx is ignored; no further ram_we or frame_err.
//   An odd trailing byte before completion stays pending; there is no timeout.
//   Counters are sized to hold WORD_COUNT and CLKS_PER_BIT-1 without overflow.
//   No combinational path from rx to any output.
// TESTING (CLKS_PER_BIT=4, WORD_COUNT=2 unless noted)
//   1 Reset: assert rst mid-run -> all outputs 0 immediately, independent of clk.
//   2 Load: send bytes 0x34,0x12,0xCD,0xAB ->
//       ram_we pulse with addr 0 / data 0x1234, then addr 1 / data 0xABCD;
//       completed=1 the cycle after the 2nd pulse.
//   3 Framing: send 0x34, then a frame with stop=0, then 0x12 ->
//       one frame_err pulse; a single write of 0x1234 to addr 0.
//   4 Glitch: 1-cycle low pulse on rx while IDLE -> no byte, no frame_err;
//       a following 0x55,0xAA writes 0xAA55.
//   5 Post-completion: after test 2, send 0xFF,0xFF -> no ram_we; completed stays 1.
//   6 Reset mid-image: rst after the first word -> next pair 0x01,0x00 writes 0x0001 to addr 0; completed=0 until 2 words.

Source files
------------

// File: rtl/uart_ram_loader.sv
// uart_ram_loader: receives an 8N1 UART image, packs byte pairs into 16-bit words
// and writes them to RAM from address 0, then raises a sticky completion flag.
module uart_ram_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 16,
    parameter int WORD_COUNT   = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_wdata,
    output logic              ram_we,
    output logic              completed,
    output logic              frame_err
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(WORD_COUNT + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_q, state_d;
    logic              rx_meta_q, rx_sync_q;
    logic [TW-1:0]     timer_q, timer_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d, low_q, low_d;
    logic              phase_q, phase_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              we_q, we_d, done_q, done_d, ferr_q, ferr_d;
    logic [CW-1:0]     wcnt_q, wcnt_d;
    logic              last_w, tick_w, half_w;

    assign last_w = we_q && wcnt_q == CW'(WORD_COUNT - 1);
    assign tick_w = timer_q == TW'(CLKS_PER_BIT - 1);
    assign half_w = timer_q == TW'(CLKS_PER_BIT / 2 - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            low_q     <= '0;
            phase_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
            wcnt_q    <= '0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            low_q     <= low_d;
            phase_q   <= phase_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
            wcnt_q    <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + TW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        low_d   = low_q;
        phase_d = phase_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        done_d  = done_q;
        ferr_d  = 1'b0;
        wcnt_d  = wcnt_q;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                state_d = rx_sync_q ? IDLE : START;
            end
            START: if (half_w) begin
                timer_d = '0;
                bit_d   = '0;
                state_d = rx_sync_q ? IDLE : DATA;
            end
            DATA: if (tick_w) begin
                timer_d = '0;
                shift_d = {rx_sync_q, shift_q[7:1]};
                bit_d   = bit_q + 3'd1;
                state_d = bit_q == 3'd7 ? STOP : DATA;
            end
            STOP: if (tick_w) begin
                timer_d = '0;
                state_d = IDLE;
                if (!rx_sync_q) ferr_d = 1'b1;
                else if (!phase_q) begin
                    low_d   = shift_q;
                    phase_d = 1'b1;
                end else begin
                    we_d    = 1'b1;
                    wdata_d = {shift_q, low_q};
                    phase_d = 1'b0;
                end
            end
        endcase
        // Once the last word is issued the receiver is frozen so nothing else reaches the outputs.
        if (done_q || last_w) begin
            state_d = IDLE;
            timer_d = '0;
            we_d    = 1'b0;
            ferr_d  = 1'b0;
            wdata_d = wdata_q;
        end
        if (we_q) begin
            if (last_w) done_d = 1'b1;
            else begin
                addr_d = addr_q + ADDR_W'(1);
                wcnt_d = wcnt_q + CW'(1);
            end
        end
    end

    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign ram_we    = we_q;
    assign completed = done_q;
    assign frame_err = ferr_q;
endmodule

// File: tb/tb_uart_ram_loader.sv
// tb_uart_ram_loader: directed scenarios for the UART image loader (CLKS_PER_BIT=4, WORD_COUNT=2).
module tb_uart_ram_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx  = 1'b1;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_we;
    logic        completed;
    logic        frame_err;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          done_cyc = -1;
    int          ferr_n = 0;
    logic [15:0] wa[$];
    logic [15:0] wd[$];
    int          wc[$];

    uart_ram_loader #(.CLKS_PER_BIT(4), .ADDR_W(16), .WORD_COUNT(2)) dut (
        .clk(clk), .rst(rst), .rx(rx), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .completed(completed), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Write/error log sampled mid-cycle
    always @(negedge clk) if (!rst) begin
        if (ram_we) begin
            wa.push_back(ram_addr);
            wd.push_back(ram_wdata);
            wc.push_back(cyc);
        end
        if (frame_err) ferr_n++;
        if (completed && done_cyc < 0) done_cyc = cyc;
    end

    task automatic clear_log;
        wa.delete();
        wd.delete();
        wc.delete();
        ferr_n = 0;
        done_cyc = -1;
    endtask

    task automatic do_reset;
        rx = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_log();
        repeat (2) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (4) @(negedge clk);
        end
        rx = stop;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_load;
        do_reset();
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'hCD, 1'b1);
        send_byte(8'hAB, 1'b1);
        repeat (4) @(negedge clk);
        n_chk++; if (wa.size() !== 2) begin n_fail++; $display("FAIL load_count got %0d exp 2", wa.size()); end
        n_chk++; if ((wa.size() > 0 ? wa[0] : 16'hxxxx) !== 16'h0000) begin n_fail++; $display("FAIL load_addr0 got %h exp 0000", wa.size() > 0 ? wa[0] : 16'hxxxx); end
        n_chk++; if ((wd.size() > 0 ? wd[0] : 16'hxxxx) !== 16'h1234) begin n_fail++; $display("FAIL load_data0 got %h exp 1234", wd.size() > 0 ? wd[0] : 16'hxxxx); end
        n_chk++; if ((wa.size() > 1 ? wa[1] : 16'hxxxx) !== 16'h0001) begin n_fail++; $display("FAIL load_addr1 got %h exp 0001", wa.size() > 1 ? wa[1] : 16'hxxxx); end
        n_chk++; if ((wd.size() > 1 ? wd[1] : 16'hxxxx) !== 16'hABCD) begin n_fail++; $display("FAIL load_data1 got %h exp abcd", wd.size() > 1 ? wd[1] : 16'hxxxx); end
        n_chk++; if (done_cyc !== (wc.size() > 1 ? wc[1] + 1 : -2)) begin n_fail++; $display("FAIL load_done_cycle got %0d exp %0d", done_cyc, wc.size() > 1 ? wc[1] + 1 : -2); end
        n_chk++; if (completed !== 1'b1) begin n_fail++; $display("FAIL load_completed got %b exp 1", completed); end
        n_chk++; if (ram_addr !== 16'h0001) begin n_fail++; $display("FAIL load_final_addr got %h exp 0001", ram_addr); end
        n_chk++; if (ferr_n !== 0) begin n_fail++; $display("FAIL load_ferr got %0d exp 0", ferr_n); end
    endtask

    task automatic test_post_completion;
        clear_log();
        send_byte(8'hFF, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h00, 1'b0);
        n_chk++; if (wa.size() !== 0) begin n_fail++; $display("FAIL post_we got %0d exp 0", wa.size()); end
        n_chk++; if (ferr_n !== 0) begin n_fail++; $display("FAIL post_ferr got %0d exp 0", ferr_n); end
        n_chk++; if (completed !== 1'b1) begin n_fail++; $display("FAIL post_completed got %b exp 1", completed); end
        n_chk++; if (ram_wdata !== 16'hABCD) begin n_fail++; $display("FAIL post_wdata got %h exp abcd", ram_wdata); end
    endtask

    task automatic test_reset;
        rx = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_chk++; if (ram_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_addr got %h exp 0000", ram_addr); end
        n_chk++; if (ram_wdata !== 16'h0000) begin n_fail++; $display("FAIL rst_wdata got %h exp 0000", ram_wdata); end
        n_chk++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL rst_we got %b exp 0", ram_we); end
        n_chk++; if (completed !== 1'b0) begin n_fail++; $display("FAIL rst_completed got %b exp 0", completed); end
        n_chk++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rst_frame_err got %b exp 0", frame_err); end
        rx = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_log();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_framing;
        do_reset();
        send_byte(8'h34, 1'b1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h12, 1'b1);
        repeat (4) @(negedge clk);
        n_chk++; if (ferr_n !== 1) begin n_fail++; $display("FAIL frm_ferr got %0d exp 1", ferr_n); end
        n_chk++; if (wa.size() !== 1) begin n_fail++; $display("FAIL frm_count got %0d exp 1", wa.size()); end
        n_chk++; if ((wa.size() > 0 ? wa[0] : 16'hxxxx) !== 16'h0000) begin n_fail++; $display("FAIL frm_addr got %h exp 0000", wa.size() > 0 ? wa[0] : 16'hxxxx); end
        n_chk++; if ((wd.size() > 0 ? wd[0] : 16'hxxxx) !== 16'h1234) begin n_fail++; $display("FAIL frm_data got %h exp 1234", wd.size() > 0 ? wd[0] : 16'hxxxx); end
        n_chk++; if (completed !== 1'b0) begin n_fail++; $display("FAIL frm_completed got %b exp 0", completed); end
    endtask

    task automatic test_glitch;
        do_reset();
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (12) @(negedge clk);
        n_chk++; if (ferr_n !== 0 || wa.size() !== 0) begin n_fail++; $display("FAIL glitch_quiet got ferr=%0d we=%0d exp 0/0", ferr_n, wa.size()); end
        send_byte(8'h55, 1'b1);
        send_byte(8'hAA, 1'b1);
        repeat (4) @(negedge clk);
        n_chk++; if (wa.size() !== 1) begin n_fail++; $display("FAIL glitch_count got %0d exp 1", wa.size()); end
        n_chk++; if ((wd.size() > 0 ? wd[0] : 16'hxxxx) !== 16'hAA55) begin n_fail++; $display("FAIL glitch_data got %h exp aa55", wd.size() > 0 ? wd[0] : 16'hxxxx); end
        n_chk++; if ((wa.size() > 0 ? wa[0] : 16'hxxxx) !== 16'h0000) begin n_fail++; $display("FAIL glitch_addr got %h exp 0000", wa.size() > 0 ? wa[0] : 16'hxxxx); end
        n_chk++; if (ferr_n !== 0) begin n_fail++; $display("FAIL glitch_ferr got %0d exp 0", ferr_n); end
    endtask

    task automatic test_reset_mid_image;
        do_reset();
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        repeat (2) @(negedge clk);
        n_chk++; if (ram_addr !== 16'h0001) begin n_fail++; $display("FAIL mid_addr_before got %h exp 0001", ram_addr); end
        do_reset();
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (4) @(negedge clk);
        n_chk++; if (wa.size() !== 1) begin n_fail++; $display("FAIL mid_count got %0d exp 1", wa.size()); end
        n_chk++; if ((wa.size() > 0 ? wa[0] : 16'hxxxx) !== 16'h0000) begin n_fail++; $display("FAIL mid_addr got %h exp 0000", wa.size() > 0 ? wa[0] : 16'hxxxx); end
        n_chk++; if ((wd.size() > 0 ? wd[0] : 16'hxxxx) !== 16'h0001) begin n_fail++; $display("FAIL mid_data got %h exp 0001", wd.size() > 0 ? wd[0] : 16'hxxxx); end
        n_chk++; if (completed !== 1'b0) begin n_fail++; $display("FAIL mid_completed_early got %b exp 0", completed); end
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (4) @(negedge clk);
        n_chk++; if ((wa.size() > 1 ? wa[1] : 16'hxxxx) !== 16'h0001) begin n_fail++; $display("FAIL mid_addr1 got %h exp 0001", wa.size() > 1 ? wa[1] : 16'hxxxx); end
        n_chk++; if ((wd.size() > 1 ? wd[1] : 16'hxxxx) !== 16'h0002) begin n_fail++; $display("FAIL mid_data1 got %h exp 0002", wd.size() > 1 ? wd[1] : 16'hxxxx); end
        n_chk++; if (completed !== 1'b1) begin n_fail++; $display("FAIL mid_completed got %b exp 1", completed); end
    endtask

    initial begin
        test_load();
        test_post_completion();
        test_reset();
        test_framing();
        test_glitch();
        test_reset_mid_image();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
